// File: rtl/operand_entry_fsm_pkg.sv
// operand_entry_fsm_pkg: shared state encodings, ALU function codes and debounce default
package operand_entry_fsm_pkg;
  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    ISSUE  = 2'd2
  } state_e;
  localparam logic [2:0] FN_ADD = 3'd0;
  localparam logic [2:0] FN_SUB = 3'd1;
  localparam logic [2:0] FN_AND = 3'd2;
  localparam logic [2:0] FN_OR  = 3'd3;
  localparam logic [2:0] FN_XOR = 3'd4;
  localparam logic [2:0] FN_NOT = 3'd5;
  localparam int DEB_CYCLES_DEF = 16;
endpackage

// File: rtl/operand_entry_fsm_if.sv
// operand_entry_fsm_if: switch/key inputs and registered operation outputs toward the ALU
interface operand_entry_fsm_if #(
  parameter int WIDTH  = 4,
  parameter int FUNC_W = 3
);
  logic [WIDTH-1:0]  sw;
  logic [FUNC_W-1:0] func_sw;
  logic              key_enter;
  logic              key_cancel;
  logic              alu_ready;
  logic [WIDTH-1:0]  a_out;
  logic [WIDTH-1:0]  b_out;
  logic [FUNC_W-1:0] func_out;
  logic              op_valid;
  logic [1:0]        state_out;
  logic [7:0]        ops_issued;
  modport master (
    input  sw, func_sw, key_enter, key_cancel, alu_ready,
    output a_out, b_out, func_out, op_valid, state_out, ops_issued
  );
  modport slave (
    output sw, func_sw, key_enter, key_cancel, alu_ready,
    input  a_out, b_out, func_out, op_valid, state_out, ops_issued
  );
endinterface

// File: rtl/operand_entry_fsm_key_conditioner.sv
// key_conditioner: synchronise an active-low key, optionally debounce (OPERAND_ENTRY_DEBOUNCE_EN), emit one-cycle press pulse
module key_conditioner
  import operand_entry_fsm_pkg::*;
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
)
`endif
(
  input  logic clock,
  input  logic resetn,
  input  logic key_n,
  output logic press
);
  logic s1_q, s1_d, s2_q, s2_d, prev_q, prev_d, lvl;
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  localparam int CW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // accept a new level only after DEB_CYCLES consecutive differing samples
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (s2_q != lvl_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) lvl_d = s2_q;
      else cnt_d = cnt_q + 1'b1;
    end
  end
  // debounce state register, released level after reset
  always_ff @(posedge clock) begin
    if (!resetn) begin
      lvl_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end
  assign lvl = lvl_q;
`else
  assign lvl = s2_q;
`endif
  // synchroniser chain and previous accepted level for edge detection
  always_comb begin
    s1_d   = key_n;
    s2_d   = s1_q;
    prev_d = lvl;
  end
  // synchroniser and edge-detect registers, released level after reset
  always_ff @(posedge clock) begin
    if (!resetn) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end
  assign press = prev_q & ~lvl;
endmodule

// File: rtl/operand_entry_fsm.sv
// operand_entry_fsm: press-driven operand A/B/function entry with valid/ready issue to the ALU (debounce via OPERAND_ENTRY_DEBOUNCE_EN)
module operand_entry_fsm
  import operand_entry_fsm_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int FUNC_W     = 3,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic                 clock,
  input  logic                 resetn,
  operand_entry_fsm_if.master  bus
);
  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [FUNC_W-1:0] f_q, f_d;
  logic [7:0]        ops_q, ops_d;
  logic              enter, cancel;
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  key_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_enter (.clock(clock), .resetn(resetn), .key_n(bus.key_enter), .press(enter));
  key_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cancel (.clock(clock), .resetn(resetn), .key_n(bus.key_cancel), .press(cancel));
`else
  key_conditioner u_enter (.clock(clock), .resetn(resetn), .key_n(bus.key_enter), .press(enter));
  key_conditioner u_cancel (.clock(clock), .resetn(resetn), .key_n(bus.key_cancel), .press(cancel));
`endif
  // entry sequence; cancel beats enter, and ISSUE ignores keys so the operation stays stable
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    f_d     = f_q;
    ops_d   = ops_q;
    case (state_q)
      WAIT_A: if (enter && !cancel) begin
        a_d     = bus.sw;
        state_d = WAIT_B;
      end
      WAIT_B: if (cancel) begin
        a_d     = '0;
        state_d = WAIT_A;
      end else if (enter) begin
        b_d     = bus.sw;
        f_d     = bus.func_sw;
        state_d = ISSUE;
      end
      ISSUE: if (bus.alu_ready) begin
        ops_d   = ops_q + 8'd1;
        state_d = WAIT_A;
      end
      default: state_d = WAIT_A;
    endcase
  end
  // state and operand registers; reset drops any pending operation
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f_q     <= f_d;
      ops_q   <= ops_d;
    end
  end
  assign bus.a_out      = a_q;
  assign bus.b_out      = b_q;
  assign bus.func_out   = f_q;
  assign bus.op_valid   = state_q == ISSUE;
  assign bus.state_out  = state_q;
  assign bus.ops_issued = ops_q;
endmodule

// File: tb/tb_operand_entry_fsm.sv
// tb_operand_entry_fsm: directed checks of entry sequence, cancel priority, issue stability, latency and counter wrap
module tb_operand_entry_fsm;
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  localparam int DEB = 4;
`else
  localparam int DEB = 0;
`endif
  localparam int HOLD = 4 + DEB;
  localparam int REL  = 3 + DEB;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  operand_entry_fsm_if #(.WIDTH(4), .FUNC_W(3)) bus ();
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  operand_entry_fsm #(.WIDTH(4), .FUNC_W(3), .DEB_CYCLES(DEB)) dut (.clock(clock), .resetn(resetn), .bus(bus));
`else
  operand_entry_fsm #(.WIDTH(4), .FUNC_W(3)) dut (.clock(clock), .resetn(resetn), .bus(bus));
`endif
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic press(input logic e, input logic c);
    bus.key_enter  = ~e;
    bus.key_cancel = ~c;
    tick(HOLD);
    bus.key_enter  = 1'b1;
    bus.key_cancel = 1'b1;
    tick(REL);
  endtask
  initial begin
    int vcnt;
    bus.sw = 4'h0;
    bus.func_sw = 3'd0;
    bus.key_enter = 1'b1;
    bus.key_cancel = 1'b1;
    bus.alu_ready = 1'b0;
    tick(2);
    check("rst_a", bus.a_out, 0);
    check("rst_b", bus.b_out, 0);
    check("rst_f", bus.func_out, 0);
    check("rst_valid", bus.op_valid, 0);
    check("rst_state", bus.state_out, 0);
    check("rst_ops", bus.ops_issued, 0);
    resetn = 1'b1;
    tick(2);
    bus.alu_ready = 1'b1;
    bus.sw = 4'h3;
    bus.key_enter = 1'b0;
    tick(2 + DEB);
    check("lat_before", bus.state_out, 0);
    tick(1);
    check("lat_state", bus.state_out, 1);
    check("lat_a", bus.a_out, 4'h3);
    tick(HOLD - 3 - DEB);
    bus.key_enter = 1'b1;
    tick(REL);
    bus.sw = 4'hA;
    bus.func_sw = 3'd1;
    bus.key_enter = 1'b0;
    vcnt = 0;
    for (int i = 0; i < HOLD + REL; i++) begin
      if (i == HOLD) bus.key_enter = 1'b1;
      tick(1);
      if (bus.op_valid) vcnt++;
    end
    check("valid_cycles", vcnt, 1);
    check("op1_a", bus.a_out, 4'h3);
    check("op1_b", bus.b_out, 4'hA);
    check("op1_f", bus.func_out, 1);
    check("op1_ops", bus.ops_issued, 1);
    check("op1_state", bus.state_out, 0);
    bus.alu_ready = 1'b0;
    bus.sw = 4'h5;
    press(1'b1, 1'b0);
    check("wb_a", bus.a_out, 4'h5);
    check("wb_state", bus.state_out, 1);
    press(1'b1, 1'b1);
    check("both_state", bus.state_out, 0);
    check("both_a", bus.a_out, 0);
    check("both_b", bus.b_out, 4'hA);
    bus.sw = 4'h6;
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check("cancel_wb_a", bus.a_out, 0);
    check("cancel_wb_state", bus.state_out, 0);
    press(1'b0, 1'b1);
    check("cancel_wa_state", bus.state_out, 0);
    press(1'b1, 1'b0);
    bus.sw = 4'h9;
    bus.func_sw = 3'd6;
    press(1'b1, 1'b0);
    check("iss_state", bus.state_out, 2);
    for (int i = 0; i < 10; i++) begin
      bus.sw = 4'(i);
      bus.func_sw = 3'(i);
      bus.key_enter = i[0];
      tick(1);
      check("iss_hold_valid", bus.op_valid, 1);
    end
    bus.key_enter = 1'b1;
    press(1'b0, 1'b1);
    check("iss_a", bus.a_out, 4'h6);
    check("iss_b", bus.b_out, 4'h9);
    check("iss_f", bus.func_out, 6);
    check("iss_valid", bus.op_valid, 1);
    bus.alu_ready = 1'b1;
    tick(1);
    check("acc_state", bus.state_out, 0);
    check("acc_valid", bus.op_valid, 0);
    check("acc_ops", bus.ops_issued, 2);
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
    bus.sw = 4'hC;
    for (int r = 0; r < 3; r++) begin
      bus.key_enter = 1'b0;
      tick(2);
      bus.key_enter = 1'b1;
      tick(2);
    end
    check("bounce_state", bus.state_out, 0);
    bus.key_enter = 1'b0;
    tick(2 + DEB);
    check("deb_before", bus.state_out, 0);
    tick(1);
    check("deb_state", bus.state_out, 1);
    check("deb_a", bus.a_out, 4'hC);
    tick(2);
    bus.key_enter = 1'b1;
    tick(REL + 2);
    bus.key_enter = 1'b0;
    tick(3);
    bus.key_enter = 1'b1;
    tick(10);
    check("glitch_state", bus.state_out, 1);
    press(1'b0, 1'b1);
    check("deb_cancel", bus.state_out, 0);
`endif
    for (int k = 0; k < 254; k++) begin
      bus.sw = 4'(k);
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      if (k == 252) check("ops_255", bus.ops_issued, 255);
    end
    check("ops_wrap", bus.ops_issued, 0);
    bus.alu_ready = 1'b0;
    bus.sw = 4'h7;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("pre_rst_valid", bus.op_valid, 1);
    resetn = 1'b0;
    bus.alu_ready = 1'b1;
    tick(1);
    check("mid_rst_valid", bus.op_valid, 0);
    check("mid_rst_state", bus.state_out, 0);
    check("mid_rst_ops", bus.ops_issued, 0);
    check("mid_rst_b", bus.b_out, 0);
    resetn = 1'b1;
    tick(3);
    check("post_rst_ops", bus.ops_issued, 0);
    check("post_rst_state", bus.state_out, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
